// File: rtl/cube_scan_driver_if.sv
// cube_scan_driver_if
//   Board-side pin bundle of the LED cube scanner: column shift-register
//   serial link plus layer drive and output blanking.
//   Parameter: DIM - cube edge length (width of LayerSel).
//   Signals:
//     SerData   column data bit into the external shift register
//     SerClk    shift clock, SerData stable at its rising edge
//     SerLatch  one-cycle storage-register latch pulse
//     LayerSel  one-hot layer drive, bit z = layer z
//     Blank     1 = outputs dark (shift-register OE)
//   Modports: master = scanner (drives pins), slave = board / observer.
interface cube_scan_driver_if #(
  parameter int unsigned DIM = 8
);
  logic           SerData;
  logic           SerClk;
  logic           SerLatch;
  logic [DIM-1:0] LayerSel;
  logic           Blank;

  modport master (
    output SerData,
    output SerClk,
    output SerLatch,
    output LayerSel,
    output Blank
  );

  modport slave (
    input SerData,
    input SerClk,
    input SerLatch,
    input LayerSel,
    input Blank
  );
endinterface

// File: rtl/cube_scan_driver.sv
// cube_scan_driver
//   Layer-multiplexing scanner for a DIM x DIM x DIM LED cube. The flat cell
//   vector is captured into a staging buffer on FrameLoad, promoted to the
//   active buffer at the start of a frame (layer 0), and streamed one layer at
//   a time MSB-first into external column shift registers. Each layer is then
//   latched, its one-hot layer select driven, and held for HOLD_CYCLES.
//   Sequence: IDLE -> SHIFT -> LATCH -> HOLD -> SHIFT ... (HOLD -> IDLE when
//   Enable is low at the end of the hold).
//
//   Parameters: DIM (edge length), CLK_DIV (Clk cycles per SerClk half
//   period, >=1), HOLD_CYCLES (hold length, multiple of 16).
//   Ports:
//     Clk, Reset_n  clock (rising edge) and asynchronous active-low reset
//     Enable        1 = scan, 0 = stop after the current layer's hold
//     Cells         cell (x,y,z) at bit z*DIM*DIM + y*DIM + x
//     FrameLoad     one-cycle strobe capturing Cells into staging
//     Brightness    [CUBE_PWM_EN only] 0..15 sixteenths of HOLD lit
//     FrameDone     one-cycle pulse when layer DIM-1 is latched
//     scan          board pins (SerData/SerClk/SerLatch/LayerSel/Blank)
//   Build option: define CUBE_PWM_EN to add Brightness and PWM blanking.
module cube_scan_driver #(
  parameter int unsigned DIM         = 8,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Enable,
  input  logic [DIM*DIM*DIM-1:0] Cells,
  input  logic                   FrameLoad,
`ifdef CUBE_PWM_EN
  input  logic [3:0]             Brightness,
`endif
  output logic                   FrameDone,
  cube_scan_driver_if.master     scan
);

  localparam int unsigned CELLS   = DIM * DIM * DIM;
  localparam int unsigned COLS    = DIM * DIM;
  localparam int unsigned BIT_T   = 2 * CLK_DIV;
  localparam int unsigned IDX_W   = (CELLS > 1)       ? $clog2(CELLS)       : 1;
  localparam int unsigned LAYER_W = (DIM > 1)         ? $clog2(DIM)         : 1;
  localparam int unsigned BIT_W   = (COLS > 1)        ? $clog2(COLS)        : 1;
  localparam int unsigned DIV_W   = (BIT_T > 1)       ? $clog2(BIT_T)       : 1;
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(DIM - 1);
  localparam logic [BIT_W-1:0]   FIRST_BIT  = BIT_W'(COLS - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(BIT_T - 1);
  localparam logic [DIV_W-1:0]   DIV_HIGH   = DIV_W'(CLK_DIV);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t             state, state_next;
  logic [LAYER_W-1:0] layer, layer_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CELLS-1:0]   staging;
  logic [CELLS-1:0]   active;
  logic               pending;
  logic [DIM-1:0]     layer_sel;
  logic               enter_shift;
  logic               swap;
  logic               bit_done;
  logic [IDX_W-1:0]   data_idx;

  assign bit_done = (div_cnt == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    layer_next  = layer;
    enter_shift = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Enable) begin
          state_next  = S_SHIFT;
          layer_next  = '0;
          enter_shift = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_done && (bit_idx == '0)) begin
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          layer_next = (layer == LAST_LAYER) ? '0 : layer + 1'b1;
          if (Enable) begin
            state_next  = S_SHIFT;
            enter_shift = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Staging is promoted on the edge that enters SHIFT for layer 0, so the
  // first bit of the frame already comes from the new active buffer.
  assign swap = enter_shift && (layer_next == '0) && pending;

  // ---------------------------------------------------------------------------
  // State, layer and phase counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      layer    <= '0;
      div_cnt  <= '0;
      bit_idx  <= FIRST_BIT;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      layer <= layer_next;

      if (state == S_SHIFT && !bit_done) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end

      if (enter_shift) begin
        bit_idx <= FIRST_BIT;
      end else if (state == S_SHIFT && bit_done && bit_idx != '0) begin
        bit_idx <= bit_idx - 1'b1;
      end

      if (state == S_HOLD && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame double buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      staging <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (FrameLoad) begin
        staging <= Cells;
      end
      if (swap) begin
        active <= staging;
      end
      // A strobe coinciding with the swap keeps its data pending for the
      // following frame; the swap itself uses the previous staging value.
      if (FrameLoad) begin
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Layer drive
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      layer_sel <= '0;
    end else if (state == S_LATCH) begin
      layer_sel <= DIM'(1) << layer;
    end else if (state_next == S_IDLE) begin
      layer_sel <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Blanking
  // ---------------------------------------------------------------------------
`ifdef CUBE_PWM_EN
  localparam int unsigned SLOT_LEN = HOLD_CYCLES / 16;
  localparam int unsigned SLOT_W   = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);

  logic [3:0]        bright_q;
  logic [SLOT_W-1:0] slot_cnt;
  logic [3:0]        slot;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bright_q <= '0;
      slot_cnt <= '0;
      slot     <= '0;
    end else begin
      if (state == S_LATCH) begin
        bright_q <= Brightness;
      end
      // slot advances every SLOT_LEN hold cycles; both reset outside HOLD.
      if (state == S_HOLD) begin
        if (slot_cnt == SLOT_LAST) begin
          slot_cnt <= '0;
          slot     <= slot + 1'b1;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end else begin
        slot_cnt <= '0;
        slot     <= '0;
      end
    end
  end

  assign scan.Blank = !((state == S_HOLD) && (slot < bright_q));
`else
  // lit: a layer has been latched since leaving IDLE, so the previous layer
  // stays visible while the next one shifts in.
  logic lit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lit <= 1'b0;
    end else if (state == S_LATCH) begin
      lit <= 1'b1;
    end else if (state_next == S_IDLE) begin
      lit <= 1'b0;
    end
  end

  assign scan.Blank = (state == S_IDLE) || ((state == S_SHIFT) && !lit);
`endif

  // ---------------------------------------------------------------------------
  // Serial outputs
  // ---------------------------------------------------------------------------
  assign data_idx = IDX_W'(layer) * IDX_W'(COLS) + IDX_W'(bit_idx);

  assign scan.SerData  = (state == S_SHIFT) ? active[data_idx] : 1'b0;
  assign scan.SerClk   = (state == S_SHIFT) && (div_cnt >= DIV_HIGH);
  assign scan.SerLatch = (state == S_LATCH);
  assign scan.LayerSel = layer_sel;
  assign FrameDone     = (state == S_LATCH) && (layer == LAST_LAYER);

endmodule

// File: tb/tb_cube_scan_driver.sv
// Directed bench for cube_scan_driver with DIM=2, CLK_DIV=1, HOLD_CYCLES=16
// (25-cycle layer period). Outputs are sampled on the falling clock edge.
module tb_cube_scan_driver;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Enable;
  logic [7:0] Cells;
  logic       FrameLoad;
  logic       FrameDone;
`ifdef CUBE_PWM_EN
  logic [3:0] Brightness;
  localparam int PWM = 1;
`else
  localparam int PWM = 0;
`endif

  cube_scan_driver_if #(.DIM(2)) bus ();

  cube_scan_driver #(
    .DIM        (2),
    .CLK_DIV    (1),
    .HOLD_CYCLES(16)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .Cells     (Cells),
    .FrameLoad (FrameLoad),
`ifdef CUBE_PWM_EN
    .Brightness(Brightness),
`endif
    .FrameDone (FrameDone),
    .scan      (bus)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect the bits present at each SerClk rising edge until SerLatch.
  task automatic capture(output logic [3:0] bits, output int nclk, output int tl,
                         output logic fd, output logic ok);
    logic prev;
    bits = '0; nclk = 0; tl = 0; fd = 1'b0; ok = 1'b0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (bus.SerClk && !prev) begin
        bits = {bits[2:0], bus.SerData};
        nclk++;
      end
      prev = bus.SerClk;
      if (bus.SerLatch) begin
        ok = 1'b1; fd = FrameDone; tl = cyc;
        break;
      end
    end
  endtask

  task automatic layer_chk(input string tag, input logic [3:0] exp_bits, input logic exp_fd,
                           output int tl);
    logic [3:0] bits; int n; logic fd; logic ok;
    capture(bits, n, tl, fd, ok);
    chk({tag, "_latch_seen"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_serclk_edges"}, 32'(n), 32'd4);
    chk({tag, "_framedone"}, 32'(fd), 32'(exp_fd));
  endtask

  initial begin
    int t0, t1, cnt;
    Reset_n = 1'b0; Enable = 1'b0; Cells = '0; FrameLoad = 1'b0;
`ifdef CUBE_PWM_EN
    Brightness = 4'd4;
`endif
    repeat (3) @(negedge Clk);
    chk("rst_serdata",  32'(bus.SerData),  32'd0);
    chk("rst_serclk",   32'(bus.SerClk),   32'd0);
    chk("rst_serlatch", 32'(bus.SerLatch), 32'd0);
    chk("rst_layersel", 32'(bus.LayerSel), 32'd0);
    chk("rst_blank",    32'(bus.Blank),    32'd1);
    chk("rst_framedone", 32'(FrameDone),   32'd0);
    Reset_n = 1'b1;

    // First frame 0xA6
    @(negedge Clk); Cells = 8'hA6; FrameLoad = 1'b1;
    @(negedge Clk); FrameLoad = 1'b0; Enable = 1'b1;
    layer_chk("f1_l0", 4'b0110, 1'b0, t0);
    @(negedge Clk);
    chk("f1_l0_layersel", 32'(bus.LayerSel), 32'd1);
    chk("f1_l0_blank", 32'(bus.Blank), 32'd0);
    layer_chk("f1_l1", 4'b1010, 1'b1, t1);
    chk("latch_period_1", 32'(t1 - t0), 32'd25);
    @(negedge Clk);
    chk("f1_l1_layersel", 32'(bus.LayerSel), 32'd2);

    // Two loads during a frame: last one (0x00) wins
    Cells = 8'hFF; FrameLoad = 1'b1;
    @(negedge Clk); Cells = 8'h00;
    @(negedge Clk); FrameLoad = 1'b0;
    layer_chk("f2_l0", 4'b0000, 1'b0, t0);
    chk("latch_period_2", 32'(t0 - t1), 32'd25);
    layer_chk("f2_l1", 4'b0000, 1'b1, t1);

    // 0x5A loaded mid-hold, 0xC3 loaded on the swap edge itself
    repeat (2) @(negedge Clk); Cells = 8'h5A; FrameLoad = 1'b1;
    @(negedge Clk); FrameLoad = 1'b0;
    repeat (13) @(negedge Clk); Cells = 8'hC3; FrameLoad = 1'b1;
    @(negedge Clk); FrameLoad = 1'b0;
    layer_chk("f3_l0", 4'b1010, 1'b0, t0);
    chk("latch_period_3", 32'(t0 - t1), 32'd25);
    layer_chk("f3_l1", 4'b0101, 1'b1, t1);
    layer_chk("f4_l0", 4'b0011, 1'b0, t0);
    layer_chk("f4_l1", 4'b1100, 1'b1, t1);

    // Enable dropped during layer 0 SHIFT
    repeat (17) @(negedge Clk); Enable = 1'b0;
    layer_chk("stop_l0", 4'b0011, 1'b0, t0);
    repeat (16) @(negedge Clk);
    chk("stop_hold_layersel", 32'(bus.LayerSel), 32'd1);
    chk("stop_hold_blank", 32'(bus.Blank), (PWM != 0) ? 32'd1 : 32'd0);
    @(negedge Clk);
    chk("stop_idle_layersel", 32'(bus.LayerSel), 32'd0);
    chk("stop_idle_blank", 32'(bus.Blank), 32'd1);
    cnt = 0;
    repeat (30) begin
      @(negedge Clk);
      if (bus.SerClk || bus.SerLatch) cnt++;
    end
    chk("stop_no_activity", 32'(cnt), 32'd0);

    // Async reset in the middle of HOLD
    Enable = 1'b1;
    layer_chk("rs_l0", 4'b0011, 1'b0, t0);
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("arst_layersel", 32'(bus.LayerSel), 32'd0);
    chk("arst_blank",    32'(bus.Blank),    32'd1);
    chk("arst_serclk",   32'(bus.SerClk),   32'd0);
    chk("arst_serlatch", 32'(bus.SerLatch), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    layer_chk("post_rst_l0", 4'b0000, 1'b0, t0);

    // Blanking over hold + following shift, then over the next period
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      if (!bus.Blank) cnt++;
    end
    chk("lit_cycles_b4", 32'(cnt), (PWM != 0) ? 32'd4 : 32'd24);
`ifdef CUBE_PWM_EN
    Brightness = 4'd0;
`endif
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      if (!bus.Blank) cnt++;
    end
    chk("lit_cycles_b0", 32'(cnt), (PWM != 0) ? 32'd0 : 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
